// File: rtl/spi_flash_reader_if.sv
//------------------------------------------------------------------------------
// spi_flash_reader_if : request/stream handshake and SPI pin bundle
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_flash_reader_if;
  logic        start;
  logic [23:0] start_addr;
  logic [23:0] byte_count;
  logic        busy;
  logic        done;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        flash_csn;
  logic        flash_sck;
  logic        flash_mosi;
  logic        flash_miso;

  modport slave (
    input  start, start_addr, byte_count, data_ready, flash_miso,
    output busy, done, data_out, data_valid, flash_csn, flash_sck, flash_mosi
  );

  modport master (
    output start, start_addr, byte_count, data_ready,
    input  busy, done, data_out, data_valid
  );

  modport flash (
    input  flash_csn, flash_sck, flash_mosi,
    output flash_miso
  );
endinterface

`default_nettype wire

// File: rtl/spi_flash_reader.sv
//------------------------------------------------------------------------------
// spi_flash_reader : SPI READ (0x03) byte streamer with one-time 0xAB wake-up
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_flash_reader #(
  parameter int CLK_DIV     = 2,
  parameter int WAKE_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  spi_flash_reader_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAKE_CMD = 3'd1;
  localparam logic [2:0] S_WAKE_GAP = 3'd2;
  localparam logic [2:0] S_CMD      = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_FINISH   = 3'd6;

  localparam logic [7:0]  C_DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] C_GAP_LAST = 16'(WAKE_CYCLES - 1);
  localparam logic [7:0]  C_CMD_WAKE = 8'hAB;
  localparam logic [7:0]  C_CMD_READ = 8'h03;

  logic [2:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] sr_q, sr_d;
  logic [7:0]  rx_q, rx_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] remain_q, remain_d;
  logic        woken_q, woken_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;
  logic [7:0]  dout_q, dout_d;
  logic        csn_q, csn_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic        w_div_end;
  logic        w_bit_end;
  logic [5:0]  w_last_bit;
  logic [31:0] w_read_frame;

  assign w_div_end    = (div_q == C_DIV_LAST);
  assign w_bit_end    = w_div_end && sck_q;
  assign w_last_bit   = (state_q == S_CMD) ? 6'd31 : 6'd7;
  // The address comes straight off the bus when CMD is entered from IDLE.
  assign w_read_frame = {C_CMD_READ, (state_q == S_IDLE) ? bus.start_addr : addr_q};

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    woken_d  = woken_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    dout_d   = dout_q;
    csn_d    = csn_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d   = 1'b1;
          addr_d   = bus.start_addr;
          remain_d = bus.byte_count;
          div_d    = 8'd0;
          bit_d    = 6'd0;
          sck_d    = 1'b0;
          if (bus.byte_count == 24'd0) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else if (!woken_q) begin
            state_d = S_WAKE_CMD;
            csn_d   = 1'b0;
            mosi_d  = C_CMD_WAKE[7];
            sr_d    = {C_CMD_WAKE[6:0], 25'd0};
          end else begin
            state_d = S_CMD;
            csn_d   = 1'b0;
            mosi_d  = w_read_frame[31];
            sr_d    = {w_read_frame[30:0], 1'b0};
          end
        end
      end

      S_WAKE_CMD, S_CMD, S_DATA: begin
        if (w_div_end) begin
          div_d = 8'd0;
          sck_d = !sck_q;
        end else begin
          div_d = div_q + 8'd1;
        end
        if (w_div_end && !sck_q && state_q == S_DATA) begin
          rx_d = {rx_q[6:0], bus.flash_miso};
        end
        if (w_bit_end) begin
          bit_d  = bit_q + 6'd1;
          mosi_d = sr_q[31];
          sr_d   = {sr_q[30:0], 1'b0};
          if (bit_q == w_last_bit) begin
            bit_d  = 6'd0;
            mosi_d = 1'b0;
            case (state_q)
              S_WAKE_CMD: begin
                state_d = S_WAKE_GAP;
                csn_d   = 1'b1;
                woken_d = 1'b1;
                gap_d   = 16'd0;
              end
              S_CMD: state_d = S_DATA;
              default: begin
                state_d = S_HOLD;
                valid_d = 1'b1;
                dout_d  = rx_q;
              end
            endcase
          end
        end
      end

      S_WAKE_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == C_GAP_LAST) begin
          state_d = S_CMD;
          csn_d   = 1'b0;
          div_d   = 8'd0;
          bit_d   = 6'd0;
          sck_d   = 1'b0;
          mosi_d  = w_read_frame[31];
          sr_d    = {w_read_frame[30:0], 1'b0};
        end
      end

      S_HOLD: begin
        // SCK is already low and csn stays low, so the flash stream resumes in place.
        if (valid_q && bus.data_ready) begin
          valid_d  = 1'b0;
          remain_d = remain_q - 24'd1;
          if (remain_q != 24'd1) begin
            state_d = S_DATA;
          end else begin
            state_d = S_FINISH;
            csn_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= 8'd0;
      bit_q    <= 6'd0;
      gap_q    <= 16'd0;
      sr_q     <= 32'd0;
      rx_q     <= 8'd0;
      addr_q   <= 24'd0;
      remain_q <= 24'd0;
      woken_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= 8'd0;
      csn_q    <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      woken_q  <= woken_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
      csn_q    <= csn_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = valid_q;
  assign bus.flash_csn  = csn_q;
  assign bus.flash_sck  = sck_q;
  assign bus.flash_mosi = mosi_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
//------------------------------------------------------------------------------
// tb_spi_flash_reader : SPI flash model, request table and randomized requests
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_flash_reader;
  localparam int CLK_DIV  = 2;
  localparam int WAKE     = 8;
  localparam int LAT_BASE = 1 + 40 * 2 * CLK_DIV;
  localparam int LAT_WAKE = 8 * 2 * CLK_DIV + WAKE;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  spi_flash_reader_if bus ();

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .WAKE_CYCLES(WAKE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit m_woken = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h100000: mem = 8'hDE;
      24'h100001: mem = 8'hAD;
      24'h100002: mem = 8'hBE;
      24'h100003: mem = 8'hEF;
      default:    mem = a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // Behavioural SPI flash: records each csn-low frame's command byte and address.
  logic [31:0] f_sr = '0;
  int          f_nbits = 0;
  int          f_dbit = 0;
  logic [7:0]  f_cmd = '0;
  logic [23:0] f_addr = '0;
  logic [23:0] f_baddr = '0;
  logic [7:0]  f_byte;
  logic        p_sck = 1'b0;
  logic        p_csn = 1'b1;
  logic [7:0]  fr_cmd[$];
  logic [23:0] fr_addr[$];

  initial bus.flash_miso = 1'b0;

  always @(bus.flash_sck or bus.flash_csn) begin
    if (bus.flash_csn !== p_csn) begin
      if (bus.flash_csn === 1'b0) begin
        f_nbits = 0; f_dbit = 0; f_sr = '0; f_cmd = '0; f_addr = '0;
      end else if (f_nbits >= 8) begin
        fr_cmd.push_back(f_cmd);
        fr_addr.push_back(f_addr);
      end
      p_csn = bus.flash_csn;
    end
    if (bus.flash_sck !== p_sck) begin
      if (bus.flash_sck === 1'b1 && bus.flash_csn === 1'b0) begin
        if (f_nbits < 32) begin
          f_sr = {f_sr[30:0], bus.flash_mosi};
          f_nbits++;
          if (f_nbits == 8) f_cmd = f_sr[7:0];
          if (f_nbits == 32) begin f_addr = f_sr[23:0]; f_baddr = f_sr[23:0]; end
        end
      end else if (bus.flash_sck === 1'b0 && bus.flash_csn === 1'b0 &&
                   f_nbits == 32 && f_cmd == 8'h03) begin
        f_byte = mem(f_baddr);
        bus.flash_miso = f_byte[7 - f_dbit];
        f_dbit++;
        if (f_dbit == 8) begin f_dbit = 0; f_baddr = f_baddr + 24'd1; end
      end
      p_sck = bus.flash_sck;
    end
  end

  int hi_run = 0;
  int last_gap = 0;
  always @(posedge clock) begin
    if (bus.flash_csn) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  // rmode: 1 ready always, 2 random ready, 3 ready low 50 cycles on byte 2.
  task automatic run_req(input string nm, input logic [23:0] a, input logic [23:0] c,
                         input int rmode, input bit ewake, input int elat, input int inj,
                         output logic [7:0] first_byte);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  n, first_v, last_hs, done_n, ndone, stall, nfr;
    bit  fin, prev_v;
    logic [7:0] held;
    for (int i = 0; i < int'(c); i++) exp_q.push_back(mem(a + 24'(i)));
    fr_cmd.delete(); fr_addr.delete();
    first_v = 0; last_hs = 0; done_n = 0; ndone = 0; stall = 0; fin = 0; prev_v = 0;
    held = '0; first_byte = '0;
    @(negedge clock);
    bus.start = 1'b1; bus.start_addr = a; bus.byte_count = c;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.start_addr = ~a; bus.byte_count = c + 24'd5;
    n = 1;
    chk({nm, " busy after start"}, 32'(bus.busy), 32'd1);
    if (c == 0) chk({nm, " done at E0+1"}, 32'(bus.done), 32'd1);
    while (!fin && n < 3000) begin
      if (bus.data_valid && first_v == 0) begin
        first_v = n;
        chk({nm, " first valid latency"}, 32'(n), 32'(elat));
      end else if (bus.data_valid && !prev_v && rmode == 1) begin
        chk({nm, " next valid latency"}, 32'(n), 32'(last_hs + 33));
      end
      prev_v = bus.data_valid;
      if (bus.done) begin
        ndone++;
        done_n = n;
        chk({nm, " busy during done"}, 32'(bus.busy), 32'd1);
      end else if (ndone > 0 && n == done_n + 1) begin
        chk({nm, " busy after done"}, 32'(bus.busy), 32'd0);
        fin = 1;
      end
      case (rmode)
        2: bus.data_ready = ($urandom_range(0, 3) != 0);
        3: begin
          if (got_q.size() == 1 && bus.data_valid && stall < 50) begin
            bus.data_ready = 1'b0;
            if (stall == 0) held = bus.data_out;
            else begin
              chk({nm, " stall data_out"}, 32'(bus.data_out), 32'(held));
              chk({nm, " stall sck"}, 32'(bus.flash_sck), 32'd0);
              chk({nm, " stall csn"}, 32'(bus.flash_csn), 32'd0);
            end
            stall++;
          end else bus.data_ready = 1'b1;
        end
        default: bus.data_ready = 1'b1;
      endcase
      if (bus.data_valid && bus.data_ready) begin
        got_q.push_back(bus.data_out);
        last_hs = n;
      end
      if (inj > 0 && n == inj) begin
        bus.start = 1'b1; bus.start_addr = 24'h222222; bus.byte_count = 24'd5;
      end else bus.start = 1'b0;
      if (!fin) begin
        @(posedge clock); #1;
        n++;
      end
    end
    bus.data_ready = 1'b0;
    chk({nm, " completed in budget"}, 32'(fin), 32'd1);
    chk({nm, " done pulses"}, 32'(ndone), 32'd1);
    chk({nm, " done timing"}, 32'(done_n), (c == 0) ? 32'd1 : 32'(last_hs + 1));
    chk({nm, " byte count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, " byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    if (got_q.size() > 0) first_byte = got_q[0];
    nfr = (c == 0) ? 0 : (ewake ? 2 : 1);
    chk({nm, " frames"}, 32'(fr_cmd.size()), 32'(nfr));
    if (fr_cmd.size() == nfr && nfr > 0) begin
      if (ewake) begin
        chk({nm, " wake cmd"}, 32'(fr_cmd[0]), 32'hAB);
        n_cmp++;
        if (last_gap < WAKE) begin
          n_bad++;
          $display("FAIL %s wake gap: got %0d cycles required >= %0d", nm, last_gap, WAKE);
        end
      end
      chk({nm, " read cmd"}, 32'(fr_cmd[nfr-1]), 32'h03);
      chk({nm, " read addr"}, 32'(fr_addr[nfr-1]), 32'(a));
    end
    if (c != 0) m_woken = 1'b1;
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [23:0] cnt;
    int          rmode;
    int          inj;
    bit          wake;
    int          lat;
    logic [7:0]  first;
  } vec_t;

  vec_t tv[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fb;
    logic [23:0] ra, rc;
    bit          rw;
    tv[0] = '{24'h100000, 24'd4, 1, 0,   1'b1, LAT_BASE + LAT_WAKE, 8'hDE};
    tv[1] = '{24'h000010, 24'd1, 1, 0,   1'b0, LAT_BASE, 8'h4A};
    tv[2] = '{24'h000000, 24'd0, 1, 0,   1'b0, 0,        8'h00};
    tv[3] = '{24'hFFFFFE, 24'd3, 1, 0,   1'b0, LAT_BASE, 8'hA4};
    tv[4] = '{24'h300000, 24'd3, 3, 0,   1'b0, LAT_BASE, 8'h6A};
    tv[5] = '{24'h004000, 24'd2, 1, 140, 1'b0, LAT_BASE, 8'h1A};

    bus.start = 1'b0; bus.start_addr = '0; bus.byte_count = '0; bus.data_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset data_valid", 32'(bus.data_valid), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset csn", 32'(bus.flash_csn), 32'd1);
    chk("reset sck", 32'(bus.flash_sck), 32'd0);
    chk("reset mosi", 32'(bus.flash_mosi), 32'd0);
    @(negedge clock) reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_req($sformatf("vec%0d", i), tv[i].addr, tv[i].cnt, tv[i].rmode, tv[i].wake,
              tv[i].lat, tv[i].inj, fb);
      if (tv[i].cnt != 0) chk($sformatf("vec%0d first byte", i), 32'(fb), 32'(tv[i].first));
    end

    // Reset during a DATA bit, then a zero-count request must not wake the flash.
    @(negedge clock);
    bus.start = 1'b1; bus.start_addr = 24'h050000; bus.byte_count = 24'd2;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (144) @(posedge clock);
    #1;
    chk("mid-data csn low", 32'(bus.flash_csn), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("reset csn", 32'(bus.flash_csn), 32'd1);
    chk("reset sck", 32'(bus.flash_sck), 32'd0);
    chk("reset valid", 32'(bus.data_valid), 32'd0);
    chk("reset busy mid", 32'(bus.busy), 32'd0);
    m_woken = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    run_req("zero unwoken", 24'h123456, 24'd0, 1, 1'b0, 0, 0, fb);
    run_req("rewake", 24'h000020, 24'd1, 1, 1'b1, LAT_BASE + LAT_WAKE, 0, fb);

    for (int k = 0; k < 6; k++) begin
      ra = 24'($urandom);
      rc = 24'($urandom_range(1, 5));
      rw = !m_woken;
      run_req($sformatf("rand%0d", k), ra, rc, 2, rw, LAT_BASE + (rw ? LAT_WAKE : 0), 0, fb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI-flash streaming reader feeding the cartridge loader's ROM-copy path. The loader gives it a 24-bit flash byte address and a byte count. The block sends the standard READ (0x03) command, then returns the data bytes one at a time over a valid/ready handshake, so the loader can stall while it writes each byte to SRAM. After reset, the first request is preceded by a Release-Power-Down (0xAB) wake command.

## Interface
- CLK_DIV, 2: SCK half-period in `clock` cycles; legal range 1..255.
- WAKE_CYCLES, 64: minimum `flash_csn`-high gap after 0xAB before the READ command.
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- start_addr  in  24  first flash byte address; latched on an accepted start.
- byte_count  in  24  number of bytes to return; latched on an accepted start; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until the cycle after `done`.
- done  out  1  one-cycle pulse when the request completes.
- data_out  out  8  returned byte; held stable while `data_valid` is high.
- data_valid  out  1  byte available.
- data_ready  in  1  consumer accepts; transfer occurs when `data_valid && data_ready`.
- flash_csn  out  1  flash chip select, active low.
- flash_sck  out  1  SPI clock, mode 0, idles low.
- flash_mosi  out  1  command/address, MSB first.
- flash_miso  in  1  flash data, MSB first.

## Operation
- Reset values: busy=0, done=0, data_valid=0, data_out=0x00, flash_csn=1, flash_sck=0, flash_mosi=0. The internal `woken` flag is cleared.
- Reset asserted mid-operation forces all outputs to these values immediately. No partial byte is presented.
- States:
  - IDLE
  - WAKE_CMD: shift 8 bits of 0xAB.
  - WAKE_GAP: csn high, count WAKE_CYCLES.
  - CMD: shift 32 bits: 0x03, then addr[23:0].
  - DATA: shift in 8 bits.
  - HOLD: data_valid=1; SCK low; csn stays low.
  - FINISH
- IDLE + start:
  - byte_count==0 → FINISH (no flash activity, no wake).
  - Otherwise !woken → WAKE_CMD.
  - Otherwise → CMD.
- Transitions:
  - WAKE_CMD → WAKE_GAP after bit 8; csn rises; woken is set.
  - WAKE_GAP → CMD after WAKE_CYCLES.
  - CMD → DATA after bit 32.
  - DATA → HOLD after bit 8.
  - HOLD + handshake → DATA if remaining count >0 after decrement, else FINISH.
  - FINISH → IDLE; `done` is high during FINISH.
- Bit timing:
  - Each bit is SCK low for CLK_DIV cycles, then SCK high for CLK_DIV cycles.
  - MOSI changes only while SCK is low: it is set on entry to the bit's low phase.
  - MISO is sampled on the clock edge that drives SCK high.
- flash_csn falls on the same edge that enters WAKE_CMD or CMD. It rises on the edge that leaves WAKE_CMD or enters FINISH.
- Back-pressure: SCK stays low and csn stays low for an unbounded time in HOLD. The flash read stream continues across stalls with no re-issue of the command.
- Remaining-count arithmetic is 24-bit unsigned. Addresses wrap inside the flash device, not in this block.
- start is ignored while busy. byte_count/start_addr changes after acceptance have no effect.

## Timing
- Accepted start (edge E0) to csn low: 1 cycle.
- First data_valid with woken=1: exactly 1 + 40·2·CLK_DIV cycles after E0 (161 at CLK_DIV=2).
- First data_valid with woken=0: adds 8·2·CLK_DIV + WAKE_CYCLES cycles.
- Each subsequent byte: data_valid rises 8·2·CLK_DIV cycles after the handshake edge, when data_ready is held high.
- data_valid falls on the edge after the handshake.
- done: 1 cycle after the final handshake. busy falls on the following edge.
- byte_count==0: done pulses 1 cycle after E0; csn never falls.

## Test plan
- Wake and read: CLK_DIV=2, WAKE_CYCLES=8, flash model with model[0x100000..3]=DE AD BE EF; start addr=0x100000, count=4, ready=1.
  - MOSI shows 0xAB, then a csn-high gap ≥8 cycles, then 03 10 00 00.
  - Data stream DE AD BE EF.
  - Exactly one done pulse.
- Second request, woken: addr=0x000010, count=1.
  - No 0xAB is sent.
  - data_valid at E0+161.
  - done at handshake+1.
- Back-pressure: count=3 with data_ready low for 50 cycles on byte 2.
  - SCK low and csn low throughout the stall.
  - data_out stable throughout the stall.
  - Bytes arrive in order with none lost.
- Zero count: start with count=0.
  - csn stays 1.
  - done pulses at E0+1.
  - Wake state unchanged.
- start while busy: pulse start (addr=0x222222) during byte 1 of a count=2 transfer.
  - Ignored; the command address is unchanged.
  - Only 2 bytes are returned.
- Reset mid-DATA: assert reset_n low during bit 4.
  - csn=1, sck=0, data_valid=0 immediately.
  - The next start re-issues 0xAB.
